io_port_peripheral: RTL and testbench

Peripheral at the far end of the processor's IN/OUT port pair. Captures every OUT write (`portOut` qualified by the IOW strobe) into a small FIFO and drains it to an external valid/ready consumer. Accepts words from an external valid/ready producer into a holding register, which is presented to the processor's `portIn` and consumed by the IOR strobe. It sits at the top level beside the processor core, on the same clock.

---
 rtl/io_port_peripheral.sv | 117 +++++++++++
 tb/tb_io_port_peripheral.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/io_port_peripheral.sv
// io_port_peripheral: OUT-strobe capture FIFO drained to a valid/ready consumer,
// plus a one-entry holding register fed by a valid/ready producer and read by IN.
// Optional feature macro: IO_PORT_OVERFLOW_EN (sticky flag for dropped OUT writes).
module io_port_peripheral #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         port_out,
  input  logic                     iow,
  output logic [WIDTH-1:0]         port_in,
  input  logic                     ior,
  output logic [WIDTH-1:0]         ext_out_data,
  output logic                     ext_out_valid,
  input  logic                     ext_out_ready,
  input  logic [WIDTH-1:0]         ext_in_data,
  input  logic                     ext_in_valid,
  output logic                     ext_in_ready,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_full,
  output logic                     in_avail,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hold_q;
  logic             avail_q;

  logic pop;
  logic push;
  logic full;
  logic accept;

  // Handshake qualifiers; a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    full   = (count == FULL_CNT);
    pop    = (count != '0) && ext_out_ready;
    push   = iow && (!full || pop);
    accept = ext_in_valid && !avail_q;
  end

  // FIFO storage: write the OUT word at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= port_out;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // One-entry IN buffer: accept only when empty, IN strobe releases it, data is kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q  <= '0;
      avail_q <= 1'b0;
    end else if (accept) begin
      hold_q  <= ext_in_data;
      avail_q <= 1'b1;
    end else if (ior && avail_q) begin
      avail_q <= 1'b0;
    end
  end

`ifdef IO_PORT_OVERFLOW_EN
  logic ovf_q;
  logic drop;

  // A write while full with no pop is lost.
  always_comb begin
    drop = iow && full && !pop;
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign ext_out_data  = mem[rd_ptr];
  assign ext_out_valid = (count != '0);
  assign out_count     = count;
  assign out_full      = full;
  assign port_in       = hold_q;
  assign in_avail      = avail_q;
  assign ext_in_ready  = !avail_q;

endmodule

// File: tb/tb_io_port_peripheral.sv
// Directed bench for io_port_peripheral (WIDTH=16, DEPTH=4).
module tb_io_port_peripheral;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] port_out;
  logic        iow;
  logic [15:0] port_in;
  logic        ior;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [2:0]  out_count;
  logic        out_full;
  logic        in_avail;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic exp_ovf;

  io_port_peripheral #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .port_out(port_out), .iow(iow), .port_in(port_in),
    .ior(ior), .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready), .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid),
    .ext_in_ready(ext_in_ready), .out_count(out_count), .out_full(out_full),
    .in_avail(in_avail), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; port_out = '0; iow = 0; ior = 0; ext_out_ready = 0;
    ext_in_data = '0; ext_in_valid = 0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (port_in !== 16'h0000) begin errors++; $display("FAIL rst_port_in: got %h want 0000", port_in); end
    checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ext_out_valid); end
    checks++; if (ext_out_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", ext_out_data); end
    checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", ext_in_ready); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", out_count); end
    checks++; if (out_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", out_full); end
    checks++; if (in_avail !== 1'b0) begin errors++; $display("FAIL rst_in_avail: got %b want 0", in_avail); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_out_order();
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    ext_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      iow = 1; port_out = vals[i];
      tick();
      checks++; if (out_count !== 3'(i + 1)) begin errors++; $display("FAIL order_count%0d: got %0d want %0d", i, out_count, i + 1); end
      checks++; if (ext_out_data !== 16'h1111) begin errors++; $display("FAIL order_head%0d: got %h want 1111", i, ext_out_data); end
    end
    iow = 0; ext_out_ready = 1;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (ext_out_data !== vals[i] || ext_out_valid !== 1'b1) begin errors++; $display("FAIL order_pop%0d: got %h/%b want %h/1", i, ext_out_data, ext_out_valid, vals[i]); end
    end
    tick();
    checks++; if (ext_out_valid !== 1'b0 || out_count !== 3'd0) begin errors++; $display("FAIL order_empty: got valid %b count %0d want 0/0", ext_out_valid, out_count); end
    ext_out_ready = 0;
  endtask

  task automatic test_full_overflow();
    ext_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      iow = 1; port_out = 16'hA000 + 16'(i);
      tick();
      if (i == 3) begin
        checks++; if (out_full !== 1'b1 || out_count !== 3'd4) begin errors++; $display("FAIL full_at4: got full %b count %0d want 1/4", out_full, out_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    iow = 0;
    checks++; if (out_full !== 1'b1 || out_count !== 3'd4) begin errors++; $display("FAIL full_after_drop: got full %b count %0d want 1/4", out_full, out_count); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf); end
    checks++; if (ext_out_data !== 16'hA000) begin errors++; $display("FAIL full_head: got %h want a000", ext_out_data); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] seq [4];
    seq[0] = 16'hA001; seq[1] = 16'hA002; seq[2] = 16'hA003; seq[3] = 16'hBEEF;
    ext_out_ready = 1; iow = 1; port_out = 16'hBEEF;
    tick();
    iow = 0;
    checks++; if (out_count !== 3'd4 || out_full !== 1'b1) begin errors++; $display("FAIL pp_count: got %0d full %b want 4/1", out_count, out_full); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL pp_ovf: got %b want %b", overflow, exp_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ext_out_data !== seq[i] || ext_out_valid !== 1'b1) begin errors++; $display("FAIL pp_seq%0d: got %h/%b want %h/1", i, ext_out_data, ext_out_valid, seq[i]); end
      tick();
    end
    checks++; if (ext_out_valid !== 1'b0 || out_count !== 3'd0) begin errors++; $display("FAIL pp_empty: got valid %b count %0d want 0/0", ext_out_valid, out_count); end
    ext_out_ready = 0;
  endtask

  task automatic test_in_handshake();
    ext_in_valid = 1; ext_in_data = 16'h5A5A;
    tick();
    checks++; if (port_in !== 16'h5A5A || in_avail !== 1'b1 || ext_in_ready !== 1'b0) begin errors++; $display("FAIL in_accept: got %h avail %b rdy %b want 5a5a/1/0", port_in, in_avail, ext_in_ready); end
    ext_in_data = 16'h6B6B;
    tick(); tick();
    checks++; if (port_in !== 16'h5A5A || in_avail !== 1'b1) begin errors++; $display("FAIL in_held_off: got %h avail %b want 5a5a/1", port_in, in_avail); end
    ior = 1;
    tick();
    ior = 0;
    checks++; if (port_in !== 16'h5A5A || in_avail !== 1'b0 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL in_ior_clear: got %h avail %b rdy %b want 5a5a/0/1", port_in, in_avail, ext_in_ready); end
    tick();
    ext_in_valid = 0;
    checks++; if (port_in !== 16'h6B6B || in_avail !== 1'b1) begin errors++; $display("FAIL in_second: got %h avail %b want 6b6b/1", port_in, in_avail); end
    ior = 1;
    tick();
    checks++; if (in_avail !== 1'b0) begin errors++; $display("FAIL in_consume2: got avail %b want 0", in_avail); end
    tick();
    ior = 0;
    checks++; if (port_in !== 16'h6B6B || in_avail !== 1'b0 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL in_idle_ior: got %h avail %b rdy %b want 6b6b/0/1", port_in, in_avail, ext_in_ready); end
  endtask

  task automatic test_reset_mid();
    ext_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      iow = 1; port_out = 16'hC001 + 16'(i);
      tick();
    end
    iow = 0; ext_in_valid = 1; ext_in_data = 16'h7777;
    tick();
    checks++; if (out_count !== 3'd3 || in_avail !== 1'b1) begin errors++; $display("FAIL mid_setup: got count %0d avail %b want 3/1", out_count, in_avail); end
    reset = 0; iow = 1; port_out = 16'hDDDD; ext_out_ready = 1; ior = 1; ext_in_data = 16'h8888;
    tick();
    checks++; if (out_count !== 3'd0 || ext_out_valid !== 1'b0 || ext_out_data !== 16'h0000) begin errors++; $display("FAIL mid_out_clr: got count %0d valid %b data %h want 0/0/0000", out_count, ext_out_valid, ext_out_data); end
    checks++; if (port_in !== 16'h0000 || in_avail !== 1'b0 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_clr: got %h avail %b rdy %b want 0000/0/1", port_in, in_avail, ext_in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_clr: got %b want 0", overflow); end
    reset = 1; iow = 0; ior = 0; ext_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ext_out_valid !== 1'b0 || ext_out_data !== 16'h0000) begin errors++; $display("FAIL mid_no_stale%0d: got valid %b data %h want 0/0000", i, ext_out_valid, ext_out_data); end
    end
  endtask

  initial begin
`ifdef IO_PORT_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    test_reset();
    test_out_order();
    test_full_overflow();
    test_full_push_pop();
    test_in_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
